// File: rtl/wb_slave_adapter_gen.sv
// Wishbone classic slave front-end for one synchronous memory-like target.
// Decodes its own byte-address window, turns byte addresses into word indices,
// issues one request per access, waits MEM_LAT cycles for read data and
// terminates with ACK (or ERR for out-of-window accesses when ERR_EN=1).
module wb_slave_adapter_gen #(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 32,
   parameter int                MEM_AW     = 10,
   parameter int                MEM_LAT    = 1,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h1000_0000),
   parameter longint            SPAN_BYTES = 4096,
   parameter bit                ERR_EN     = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   wb_adr_i,
   input  logic [DATA_W-1:0]   wb_dat_i,
   output logic [DATA_W-1:0]   wb_dat_o,
   input  logic                wb_we_i,
   input  logic [DATA_W/8-1:0] wb_sel_i,
   input  logic                wb_stb_i,
   input  logic                wb_cyc_i,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic [MEM_AW-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                mem_we_o,
   output logic                mem_en_o,
   output logic [DATA_W/8-1:0] mem_sel_o,
   output logic                busy_o
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFFS  = (BYTES > 1) ? $clog2(BYTES) : 0;
   // Window bounds carry one extra bit so BASE_ADDR+SPAN_BYTES cannot wrap.
   localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(SPAN_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ACK,
      S_ERR
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [3:0]          cnt;
   logic [ADDR_W-1:0]   lat_adr;
   logic [DATA_W-1:0]   lat_dat;
   logic [BYTES-1:0]    lat_sel;
   logic                lat_we;
   logic [DATA_W-1:0]   rd_data;
   logic                req;
   logic                in_window;
   logic                capture;
   logic                zero_dat;

   assign req       = wb_cyc_i & wb_stb_i;
   assign in_window = ({1'b0, wb_adr_i} >= WIN_LO) && ({1'b0, wb_adr_i} < WIN_HI);

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state decode plus the read-data capture/clear strobes.
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      zero_dat   = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (in_window) begin
                  next_state = S_REQ;
               end else if (ERR_EN) begin
                  next_state = S_ERR;
               end else begin
                  next_state = S_ACK;
                  zero_dat   = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (!wb_cyc_i) begin
               next_state = S_IDLE;
            end else if (MEM_LAT == 0) begin
               next_state = S_ACK;
               capture    = ~lat_we;
            end else begin
               next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!wb_cyc_i) begin
               next_state = S_IDLE;
            end else if (cnt == 4'd1) begin
               next_state = S_ACK;
               capture    = ~lat_we;
            end
         end
         S_ACK:   next_state = S_IDLE;
         S_ERR:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Latency counter: loaded in REQ, counts down through WAIT.
   always_ff @(posedge clk_i) begin
      if (!rst_n)                cnt <= 4'd0;
      else if (state == S_REQ)   cnt <= 4'(MEM_LAT);
      else if (state == S_WAIT)  cnt <= cnt - 4'd1;
   end

   // Request latches, captured when a cycle is accepted in IDLE.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         lat_adr <= '0;
         lat_dat <= '0;
         lat_sel <= '0;
         lat_we  <= 1'b0;
      end else if (state == S_IDLE && req) begin
         lat_adr <= wb_adr_i;
         lat_dat <= wb_dat_i;
         lat_sel <= wb_sel_i;
         lat_we  <= wb_we_i;
      end
   end

   // Registered read data: cleared for silent out-of-window acks.
   always_ff @(posedge clk_i) begin
      if (!rst_n)        rd_data <= '0;
      else if (zero_dat) rd_data <= '0;
      else if (capture)  rd_data <= mem_rdata_i;
   end

   assign wb_dat_o    = rd_data;
   assign wb_ack_o    = (state == S_ACK) & wb_cyc_i;
   assign wb_err_o    = (state == S_ERR) & wb_cyc_i;
   assign busy_o      = (state != S_IDLE);
   assign mem_en_o    = (state == S_REQ);
   assign mem_we_o    = (state == S_REQ) & lat_we;
   assign mem_wdata_o = lat_dat;
   assign mem_sel_o   = lat_sel;
   // Word index is only driven while an in-window access is in flight.
   assign mem_addr_o  = (state == S_REQ || state == S_WAIT || state == S_ACK)
                        ? MEM_AW'((lat_adr - BASE_ADDR) >> OFFS) : '0;

endmodule

// File: doc/wb_slave_adapter_gen.md
Name: wb_slave_adapter_gen

Overview:
Parametrised Wishbone classic slave front-end that replaces the fixed single-wait adapter in front of on-chip memories and IP register banks.
- Decodes its own address window and translates byte addresses to word indices.
- Issues a single-cycle request to a synchronous memory with configurable read latency, and registers read data.
- Terminates each cycle with ACK, or with ERR for out-of-window accesses.
- Sits between the NoC/Wishbone interconnect and one memory-like target.

Parameters:
- DATA_W, 32: data width in bits; multiple of 8, min 8.
- ADDR_W, 32: Wishbone byte-address width.
- MEM_AW, 10: memory word-address width.
- MEM_LAT, 1: memory read latency in cycles, from mem_en_o to valid mem_rdata_i; range 0..15.
- BASE_ADDR, 32'h1000_0000: first byte address of the window; aligned to DATA_W/8.
- SPAN_BYTES, 4096: window size in bytes; at most (2**MEM_AW)*(DATA_W/8).
- ERR_EN, 1: 1 = out-of-window access ends with wb_err_o; 0 = ends with wb_ack_o and read data 0.

Ports:
- clk_i, input, 1: clock; all logic on rising edge.
- rst_n, input, 1: synchronous active-low reset.
- wb_adr_i, input, ADDR_W: byte address.
- wb_dat_i, input, DATA_W: write data.
- wb_dat_o, output, DATA_W: registered read data.
- wb_we_i, input, 1: 1 = write.
- wb_sel_i, input, DATA_W/8: byte lane select.
- wb_stb_i, input, 1: strobe.
- wb_cyc_i, input, 1: cycle valid.
- wb_ack_o, output, 1: normal termination.
- wb_err_o, output, 1: error termination.
- mem_addr_o, output, MEM_AW: word index.
- mem_wdata_o, output, DATA_W: write data to memory.
- mem_rdata_i, input, DATA_W: read data from memory.
- mem_we_o, output, 1: memory write enable.
- mem_en_o, output, 1: memory request; exactly one pulse per accepted in-window access.
- mem_sel_o, output, DATA_W/8: byte enables to memory.
- busy_o, output, 1: high in every state except IDLE.

Behaviour:
- Reset: on rst_n=0 at a clock edge, state goes to IDLE, counter to 0, and wb_dat_o and the latched addr/data/sel/we go to 0. This overrides any in-flight transfer. All outputs read 0 in the following cycle.
- States: IDLE, REQ, WAIT, ACK, ERR.
- IDLE:
  - On wb_cyc_i & wb_stb_i, latch wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i.
  - In window means BASE_ADDR <= adr < BASE_ADDR+SPAN_BYTES, compared at ADDR_W+1 bits so the upper bound cannot overflow.
  - In window -> REQ.
  - Out of window: ERR_EN=1 -> ERR; ERR_EN=0 -> ACK with wb_dat_o loaded 0. No memory access occurs.
- REQ (1 cycle):
  - mem_en_o=1 and mem_we_o=latched we.
  - mem_addr_o = (adr-BASE_ADDR) >> log2(DATA_W/8), truncated to MEM_AW.
  - mem_wdata_o and mem_sel_o come from the latches and are held stable from REQ through ACK.
  - Counter loads MEM_LAT.
  - MEM_LAT=0: capture mem_rdata_i at the end of REQ, then -> ACK. Otherwise -> WAIT.
- WAIT: lasts exactly MEM_LAT cycles. Counter decrements each cycle; when it is 1, capture mem_rdata_i (reads only), then -> ACK.
- Writes: follow the same path and latency; wb_dat_o is unchanged.
- ACK: wb_ack_o = (state==ACK) & wb_cyc_i, high for exactly one cycle, then -> IDLE.
- ERR: wb_err_o = (state==ERR) & wb_cyc_i, high for one cycle, then -> IDLE. wb_ack_o and wb_err_o are never high together.
- Latency: request sampled in cycle 0 gives termination in cycle 2+MEM_LAT for in-window accesses, and in cycle 1 for out-of-window accesses.
- Throughput: the next request is accepted at the earliest in the cycle after ACK/ERR.
- Abort: wb_cyc_i=0 in REQ, WAIT, ACK or ERR -> next state IDLE with no termination pulse.
  - A write already issued in REQ is not undone.
  - A read abort leaves wb_dat_o unchanged, unless the capture edge has already occurred.
- wb_stb_i is ignored outside IDLE; the master must hold it with stable signals until termination.
- wb_sel_i=0: proceeds normally. mem_en_o still pulses with mem_sel_o=0, so the memory writes no lanes.
- mem_en_o and mem_we_o are 0 in every state other than REQ.

Test Plan (DATA_W=32, MEM_LAT=1, BASE_ADDR=0x1000_0000, SPAN_BYTES=4096 unless stated):
- Write: adr=0x1000_0008, dat=0xDEADBEEF, sel=0xF, cycle 0 -> cycle 1 mem_en=1, mem_we=1, mem_addr=2; cycle 3 wb_ack_o=1 for one cycle; busy_o high in cycles 1-3.
- Read of the same address -> cycle 3 ack with wb_dat_o=0xDEADBEEF; mem_we_o stays 0.
- Byte write: sel=0x2, dat=0x0000AB00 -> mem_sel_o=0x2. A later read returns 0xDEADABEF.
- Out of window: adr=0x2000_0000. ERR_EN=1 -> wb_err_o=1 in cycle 1, no mem_en pulse. ERR_EN=0 -> wb_ack_o=1 in cycle 1, wb_dat_o=0. Address 0x1000_1000 (upper bound) is also out of window.
- Abort and reset:
  - Read with MEM_LAT=3; drop wb_cyc_i in the 2nd WAIT cycle -> no ack, IDLE next cycle; next read is accepted and acked at cycle 5.
  - rst_n=0 for one cycle mid-WAIT -> all outputs 0, IDLE.
- Latency sweep: MEM_LAT=0 -> ack in cycle 2; MEM_LAT=3 -> ack in cycle 5. Back-to-back reads show one idle cycle between ack and the next mem_en.
